// File: rtl/unary_decoder_if.sv
// ---------------------------------------------------------------------------
// unary_decoder_if
//   Groups the bitstream input, the result handshake and the status outputs of
//   unary_decoder.
//   slave  : decoder side (consumes the stream, produces the result)
//   master : driver/consumer side (produces the stream, accepts the result)
//   Signals:
//     start      begin a new frame (one-cycle pulse)
//     bit_in     unary stream bit, qualified by bit_valid
//     bit_valid  bit_in qualifier
//     out_ready  consumer accepts result
//     out_valid  result held stable until accepted
//     scalar_out decoded 8-bit scalar
//     ones_out   raw count of 1s in the frame (WIDTH+1 bits)
//     sat        decoded value saturated at 255
//     busy       frame accumulation in progress
//     frame_pos  index of the next bit to be sampled
// ---------------------------------------------------------------------------
interface unary_decoder_if #(
   parameter int WIDTH = 10
);
   logic             start;
   logic             bit_in;
   logic             bit_valid;
   logic             out_ready;
   logic             out_valid;
   logic [7:0]       scalar_out;
   logic [WIDTH:0]   ones_out;
   logic             sat;
   logic             busy;
   logic [WIDTH-1:0] frame_pos;

   modport slave (
      input  start, bit_in, bit_valid, out_ready,
      output out_valid, scalar_out, ones_out, sat, busy, frame_pos
   );

   modport master (
      output start, bit_in, bit_valid, out_ready,
      input  out_valid, scalar_out, ones_out, sat, busy, frame_pos
   );
endinterface

// File: rtl/unary_decoder.sv
// ---------------------------------------------------------------------------
// unary_decoder
//   Counts the 1s in one frame of 2**WIDTH valid bits of a unary/stochastic
//   bitstream and recovers the 8-bit scalar (ones >> (WIDTH-8), saturated at
//   255). The latched result is offered on a valid/ready handshake.
//   Ports:
//     clk    clock, rising edge
//     reset  synchronous, active-high
//     dec    unary_decoder_if.slave (stream in, result/status out)
//   Parameters:
//     WIDTH  log2 of the frame length; must be >= 8
// ---------------------------------------------------------------------------
module unary_decoder #(
   parameter int WIDTH = 10
) (
   input  logic         clk,
   input  logic         reset,
   unary_decoder_if.slave dec
);

   localparam int SHIFT = WIDTH - 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t           state_q;
   state_t           state_d;

   logic [WIDTH:0]   ones_p0;
   logic [WIDTH-1:0] frame_pos_p0;
   logic [WIDTH:0]   ones_out_p1;
   logic [7:0]       scalar_p1;
   logic             sat_p1;

   logic [WIDTH:0]   ones_next;
   logic [8:0]       shifted;
   logic [8:0]       sat_scalar;
   logic             accept;
   logic             last_bit;
   logic             clear;

   // Returns {sat, scalar}: only an all-ones frame reaches 256 after the shift.
   function automatic logic [8:0] saturate_scalar(input logic [8:0] v);
      if (v[8])
         return {1'b1, 8'hFF};
      else
         return {1'b0, v[7:0]};
   endfunction

   assign ones_next  = ones_p0 + {{WIDTH{1'b0}}, dec.bit_in};
   assign shifted    = 9'(ones_next >> SHIFT);
   assign sat_scalar = saturate_scalar(shifted);

   // start in ACCUM aborts the frame, so it takes priority over a valid bit.
   assign accept   = (state_q == ACCUM) && !dec.start && dec.bit_valid;
   assign last_bit = (frame_pos_p0 == {WIDTH{1'b1}});

   // A result awaiting acceptance is never discarded by start alone.
   assign clear = dec.start &&
                  ((state_q == IDLE) || (state_q == ACCUM) ||
                   ((state_q == DONE) && dec.out_ready));

   // State register
   always_ff @(posedge clk) begin
      if (reset)
         state_q <= IDLE;
      else
         state_q <= state_d;
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (dec.start)
               state_d = ACCUM;
         end
         ACCUM: begin
            if (!dec.start && dec.bit_valid && last_bit)
               state_d = DONE;
         end
         DONE: begin
            if (dec.out_ready)
               state_d = dec.start ? ACCUM : IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Output logic
   always_comb begin
      dec.out_valid = (state_q == DONE);
      dec.busy      = (state_q == ACCUM);
   end

   // Stage p0: running count and frame position
   always_ff @(posedge clk) begin
      if (reset) begin
         ones_p0      <= '0;
         frame_pos_p0 <= '0;
      end else if (clear) begin
         ones_p0      <= '0;
         frame_pos_p0 <= '0;
      end else if (accept) begin
         ones_p0      <= ones_next;
         frame_pos_p0 <= frame_pos_p0 + 1'b1;
      end
   end

   // Stage p1: latched result, written only on the last accepted bit
   always_ff @(posedge clk) begin
      if (reset) begin
         ones_out_p1 <= '0;
         scalar_p1   <= '0;
         sat_p1      <= 1'b0;
      end else if (accept && last_bit) begin
         ones_out_p1 <= ones_next;
         scalar_p1   <= sat_scalar[7:0];
         sat_p1      <= sat_scalar[8];
      end
   end

   assign dec.ones_out   = ones_out_p1;
   assign dec.scalar_out = scalar_p1;
   assign dec.sat        = sat_p1;
   assign dec.frame_pos  = frame_pos_p0;

endmodule
